// File: rtl/dbus_sram_responder_if.sv
// dbus_sram_responder_if
//   Request/response bundle between the pipeline memory stage (master) and a
//   data-bus target (slave).
//   dreq  : valid, addr (byte address), size (0=1B,1=2B,2=4B,3=8B),
//           strobe (byte write enables, 0 = read), data (write data)
//   dresp : addr_ok (request accepted this cycle), data_ok (response valid
//           this cycle), data (aligned 64-bit word)
interface dbus_sram_responder_if;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [1:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   dbus_req_t  dreq;
   dbus_resp_t dresp;

   modport master (output dreq, input dresp);
   modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder
//   Target end of the data bus: a single-ported 64-bit-wide SRAM model with a
//   configurable access latency. One request is in flight at a time; writes
//   are byte-strobed, reads return the full aligned word.
//
//   Ports
//     clk   : clock
//     reset : synchronous active-high reset
//     bus   : dbus_sram_responder_if.slave (dreq in, dresp out)
//     err   : misaligned-access flag, qualified by dresp.data_ok
//
//   Parameters
//     DEPTH_LOG2 : log2 of the number of 64-bit words
//     LATENCY    : BUSY cycles before the access commits (1..15)
//     BASE_ADDR  : byte address of word 0 (8-byte aligned)
//
//   Optional feature (macro DBUS_RESP_ALIGN_CHECK_EN)
//     When defined, the latched address is checked against size. A misaligned
//     access writes nothing, returns 0 and raises err alongside data_ok.
//     When undefined, err is tied low and no check logic exists.
module dbus_sram_responder #(
   parameter int          DEPTH_LOG2 = 12,
   parameter int          LATENCY    = 2,
   parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   dbus_sram_responder_if.slave  bus,
   output logic                  err
);

   localparam int          DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [63:3] addr_q;      // word address; byte offset only matters to the check
   logic [7:0]  strb_q;
   logic [63:0] wdata_q;
   logic [63:0] rdata;
   logic        data_ok_q;

   logic [63:0] mem [DEPTH];

   // Word offset from the base. The upper bits being zero is exactly the
   // in-range test; addresses below BASE_ADDR wrap to huge offsets and fail it.
   logic [60:0]           word_off;
   logic                  in_range;
   logic [DEPTH_LOG2-1:0] idx;
   logic [63:0]           cur_word;
   logic [63:0]           merged;
   logic                  is_wr;
   logic                  commit;
   logic                  misalign;
   logic [63:0]           commit_data;

   assign word_off = addr_q - BASE_ADDR[63:3];
   assign in_range = (word_off[60:DEPTH_LOG2] == '0);
   assign idx      = word_off[DEPTH_LOG2-1:0];
   assign cur_word = mem[idx];
   assign is_wr    = |strb_q;
   assign commit   = (state == BUSY) && (cnt == 4'd0);

   always_comb begin
      merged = cur_word;
      for (int i = 0; i < 8; i++)
         if (strb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
   end

`ifdef DBUS_RESP_ALIGN_CHECK_EN
   logic [2:0] addr_lo_q;
   logic [1:0] size_q;
   logic       err_q;

   always_comb begin
      misalign = 1'b0;
      case (size_q)
         2'd1:    misalign = addr_lo_q[0];
         2'd2:    misalign = |addr_lo_q[1:0];
         2'd3:    misalign = |addr_lo_q;
         default: misalign = 1'b0;
      endcase
   end

   // Only the byte offset and size feed the check, so they are captured here
   // and nowhere else.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         if (state == IDLE && bus.dreq.valid) begin
            addr_lo_q <= bus.dreq.addr[2:0];
            size_q    <= bus.dreq.size;
         end
         if (commit) err_q <= misalign;
         else        err_q <= 1'b0;
      end
   end

   assign err = err_q;
`else
   assign misalign = 1'b0;
   assign err      = 1'b0;
`endif

   // Out-of-range and misaligned accesses both read back as zero; a write
   // returns the merged word it just stored.
   always_comb begin
      commit_data = 64'h0;
      if (in_range && !misalign)
         commit_data = is_wr ? merged : cur_word;
   end

   // Array has no reset. The !reset term keeps a reset on the commit edge
   // from letting the write through.
   always_ff @(posedge clk) begin
      if (!reset && commit && is_wr && in_range && !misalign)
         mem[idx] <= merged;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         rdata     <= 64'h0;
         data_ok_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               data_ok_q <= 1'b0;
               if (bus.dreq.valid) begin
                  addr_q  <= bus.dreq.addr[63:3];
                  strb_q  <= bus.dreq.strobe;
                  wdata_q <= bus.dreq.data;
                  cnt     <= CNT_INIT;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  rdata     <= commit_data;
                  data_ok_q <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // Always return to IDLE so a request still held high is not
               // accepted a second time in the same cycle as its response.
               data_ok_q <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               data_ok_q <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.dresp.addr_ok = (state == IDLE) && bus.dreq.valid && !reset;
   assign bus.dresp.data_ok = data_ok_q;
   assign bus.dresp.data    = rdata;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder (LATENCY=2, default depth/base).
module tb_dbus_sram_responder;

   localparam int LAT = 2;
   localparam logic [1:0] MS1 = 2'd0, MS2 = 2'd1, MS4 = 2'd2, MS8 = 2'd3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic err;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   dbus_sram_responder_if bus();

   dbus_sram_responder #(.DEPTH_LOG2(12), .LATENCY(LAT),
                         .BASE_ADDR(64'h0000_0000_8000_0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .err   (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] data;
      logic        err;
      bit          dc;     // data not checked
      int          cyc;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [63:0] addr;
      logic [7:0]  strb;
      logic [63:0] data;
      logic [1:0]  size;
      logic [63:0] exp;
      bit          dc;
   } vec_t;
   vec_t vt[14];

   function automatic vec_t mk(input logic [63:0] a, input logic [7:0] s,
                               input logic [63:0] d, input logic [1:0] sz,
                               input logic [63:0] e, input bit dc);
      vec_t v;
      v.addr = a; v.strb = s; v.data = d; v.size = sz; v.exp = e; v.dc = dc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Scoreboard monitor: every data_ok must match the oldest outstanding
   // request, on the predicted cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.dresp.data_ok) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_data_ok at cycle %0d", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("data_ok_cycle", 64'(cyc), 64'(e.cyc));
               if (!e.dc) chk("resp_data", bus.dresp.data, e.data);
               chk("resp_err", 64'(err), 64'(e.err));
            end
         end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
            checks++; errors++;
            $display("FAIL missing_data_ok: expected at cycle %0d, now %0d", sb[0].cyc, cyc);
            void'(sb.pop_front());
         end
      end
   end

   task automatic req(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                      input logic [1:0] sz, input logic [63:0] e, input logic e_err,
                      input bit dc, input bit drop);
      exp_t x;
      @(negedge clk);
      bus.dreq.valid = 1'b1; bus.dreq.addr = a; bus.dreq.strobe = s;
      bus.dreq.data = d; bus.dreq.size = sz;
      #1;
      chk("addr_ok_accept", 64'(bus.dresp.addr_ok), 64'd1);
      x.data = e; x.err = e_err; x.dc = dc; x.cyc = cyc + LAT + 1;
      sb.push_back(x);
      for (int i = 1; i <= LAT + 1; i++) begin
         @(negedge clk);
         if (drop && i == 1) bus.dreq.valid = 1'b0;
         #1;
         if (bus.dreq.valid) chk("addr_ok_held", 64'(bus.dresp.addr_ok), 64'd0);
      end
      @(negedge clk);
      bus.dreq.valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bus.dreq.valid = 1'b0; bus.dreq.addr = '0; bus.dreq.size = '0;
      bus.dreq.strobe = '0; bus.dreq.data = '0;

      vt[0]  = mk(64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, MS8, 64'h1122_3344_5566_7788, 0);
      vt[1]  = mk(64'h8000_0010, 8'h00, 64'h0,                   MS8, 64'h1122_3344_5566_7788, 0);
      vt[2]  = mk(64'h8000_0013, 8'h08, 64'h0000_0000_AB00_0000, MS1, 64'h1122_3344_AB66_7788, 0);
      vt[3]  = mk(64'h8000_0010, 8'h00, 64'h0,                   MS8, 64'h1122_3344_AB66_7788, 0);
      vt[4]  = mk(64'h8000_0000, 8'hFF, 64'hCAFE_F00D_0BAD_BEEF, MS8, 64'hCAFE_F00D_0BAD_BEEF, 0);
      vt[5]  = mk(64'h8000_0000, 8'h81, 64'h5500_0000_0000_0066, MS8, 64'h55FE_F00D_0BAD_BE66, 0);
      vt[6]  = mk(64'h8000_7FF8, 8'hFF, 64'hAAAA_BBBB_CCCC_DDDD, MS8, 64'hAAAA_BBBB_CCCC_DDDD, 0);
      vt[7]  = mk(64'h8000_7FFF, 8'h00, 64'h0,                   MS1, 64'hAAAA_BBBB_CCCC_DDDD, 0);
      vt[8]  = mk(64'h7FFF_FFF8, 8'h00, 64'h0,                   MS8, 64'h0, 0);
      vt[9]  = mk(64'h7FFF_FFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, MS8, 64'h0, 1);
      vt[10] = mk(64'h8000_8000, 8'hFF, 64'h1234_5678_9ABC_DEF0, MS8, 64'h0, 1);
      vt[11] = mk(64'h8000_8000, 8'h00, 64'h0,                   MS8, 64'h0, 0);
      vt[12] = mk(64'h8000_0000, 8'h00, 64'h0,                   MS8, 64'h55FE_F00D_0BAD_BE66, 0);
      vt[13] = mk(64'h8000_7FF8, 8'h00, 64'h0,                   MS8, 64'hAAAA_BBBB_CCCC_DDDD, 0);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_addr_ok", 64'(bus.dresp.addr_ok), 64'd0);
      chk("rst_data_ok", 64'(bus.dresp.data_ok), 64'd0);
      chk("rst_data",    bus.dresp.data,         64'd0);
      chk("rst_err",     64'(err),               64'd0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_addr_ok", 64'(bus.dresp.addr_ok), 64'd0);
         chk("idle_data_ok", 64'(bus.dresp.data_ok), 64'd0);
         chk("idle_data",    bus.dresp.data,         64'd0);
         chk("idle_err",     64'(err),               64'd0);
      end
      mon_en = 1'b1;

      for (int i = 0; i < 14; i++)
         req(vt[i].addr, vt[i].strb, vt[i].data, vt[i].size, vt[i].exp, 1'b0, vt[i].dc, 1'b0);

      // Valid dropped during BUSY still completes
      req(64'h8000_0010, 8'h00, 64'h0, MS8, 64'h1122_3344_AB66_7788, 1'b0, 0, 1'b1);

      // Reset in first BUSY cycle of a write: no response, no commit
      @(negedge clk);
      bus.dreq.valid = 1'b1; bus.dreq.addr = 64'h8000_0010; bus.dreq.strobe = 8'hFF;
      bus.dreq.data = 64'hDEAD; bus.dreq.size = MS8;
      @(negedge clk);
      reset = 1'b1; bus.dreq.valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_data", bus.dresp.data, 64'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("midrst_data_ok", 64'(bus.dresp.data_ok), 64'd0);
      end
      req(64'h8000_0010, 8'h00, 64'h0, MS8, 64'h1122_3344_AB66_7788, 1'b0, 0, 1'b0);

`ifdef DBUS_RESP_ALIGN_CHECK_EN
      req(64'h8000_0012, 8'h0C, 64'h0000_0000_DEAD_0000, MS4, 64'h0, 1'b1, 0, 1'b0);
      req(64'h8000_0010, 8'h00, 64'h0, MS8, 64'h1122_3344_AB66_7788, 1'b0, 0, 1'b0);
`endif

      repeat (6) @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dbus_sram_responder.md
Name: dbus_sram_responder

Overview:
Data-bus responder: the target end of the dbus_req_t/dbus_resp_t handshake driven by the pipeline memory stage. It models a single-ported 64-bit-wide data SRAM with configurable access latency. It accepts one request at a time and performs byte-strobed writes or full-word reads. Lane placement and sign extension stay in the memory stage, so this block always returns the aligned 64-bit word.

Parameters:
DEPTH_LOG2, 12, log2 of number of 64-bit words (default 32 KiB)
LATENCY, 2, cycles spent in BUSY before the access commits; legal range 1..15
BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
dreq  input  dbus_req_t  request: valid, addr, size, strobe, data
dresp  output  dbus_resp_t  response: addr_ok, data_ok, data
err  output  1  misaligned-access flag, valid with data_ok (see Optional Feature)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset), sampled on rising clk.
- Storage: 2^DEPTH_LOG2 x 64-bit array. Offset = addr - BASE_ADDR. Index = offset[DEPTH_LOG2+2:3]. addr[2:0] is ignored for storage.
- In range: BASE_ADDR <= addr < BASE_ADDR + 8*2^DEPTH_LOG2. Out-of-range reads return 64'h0. Out-of-range writes are dropped. Both still complete the handshake.
- Access type: strobe != 0 means write; strobe == 0 means read. Write merge: byte i of the word takes data[8i+7:8i] iff strobe[i]. size has no effect on the datapath.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: dresp.addr_ok = dreq.valid (combinational). If valid, latch addr, strobe, data and size, load cnt = LATENCY-1, and go to BUSY.
  - BUSY: dreq is ignored entirely. If cnt != 0, decrement cnt. If cnt == 0, commit the access on this edge (write merge, or read word into rdata; for a write, rdata gets the merged new word), then go to DONE.
  - DONE: dresp.data_ok = 1 and dresp.data = rdata for exactly one cycle, then go to IDLE unconditionally.
- Latency: a request accepted in cycle T gives data_ok in cycle T+LATENCY+1. The next acceptance is possible no earlier than T+LATENCY+2.
- The initiator holds valid high through DONE. The DONE-to-IDLE transition ensures a held request is never accepted twice. A new request presented in the IDLE cycle after DONE is accepted normally.
- Once accepted, a request is committed. Deasserting valid during BUSY does not cancel it, and data_ok still pulses.
- dresp.data holds its last value outside DONE; only data_ok qualifies it. addr_ok is 0 in BUSY and DONE.
- Reset values: state IDLE, cnt 0, rdata 0, dresp.addr_ok 0, dresp.data_ok 0, dresp.data 0, err 0. Array contents are not reset.
- Reset mid-operation: the outstanding request is discarded. A write does not commit unless its commit edge already occurred. No data_ok is produced.

Optional Feature:
- Macro: DBUS_RESP_ALIGN_CHECK_EN.
- With the macro defined, the latched addr is checked against size: MSIZE2 needs addr[0]==0, MSIZE4 needs addr[1:0]==0, MSIZE8 needs addr[2:0]==0.
  - On a misaligned access, the commit edge performs no write and sets rdata to 0.
  - err = 1 in the DONE cycle, alongside data_ok.
  - Timing is unchanged.
- Without the macro, err is tied to 0 and no check logic is generated.

Test Plan:
- Reset held 2 cycles, then valid=0 for 5 cycles -> addr_ok=0, data_ok=0, data=0, err=0 throughout.
- LATENCY=2; write addr 0x8000_0010, strobe 0xFF, data 0x1122334455667788, accepted at cycle 0 -> addr_ok in cycle 0, single data_ok in cycle 3. Then read the same addr -> data_ok 3 cycles after accept, data 0x1122334455667788.
- Byte write addr 0x8000_0013, strobe 0x08, data 0x0000_0000_AB00_0000, then read addr 0x8000_0010 -> data 0x11223344AB667788.
- valid held high from accept through DONE, then dropped in the IDLE cycle -> exactly one data_ok and one commit. A second request with valid dropped during BUSY -> still completes with data_ok at T+3.
- Read addr 0x7FFF_FFF8 -> data 0, data_ok at T+3. Write 0x7FFF_FFF8 with strobe 0xFF -> no in-range word changes.
- Reset asserted in the first BUSY cycle of a write of 0xDEAD to 0x8000_0010 -> no data_ok. A subsequent read returns the previous 0x11223344AB667788. With DBUS_RESP_ALIGN_CHECK_EN, an MSIZE4 write to 0x8000_0012 -> err=1 with data_ok, data 0, memory unchanged.
